zap_mmu_desc_responder: RTL and testbench

ZAP_MMU_DESC_RESPONDER -- requirements
Module: zap_mmu_desc_responder

---
 rtl/zap_mmu_desc_responder.sv | 227 ++++++++++++++++++++++
 tb/tb_zap_mmu_desc_responder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zap_mmu_desc_responder.sv
// Descriptor read responder for the MMU table walker. It keeps a small
// fully-associative buffer of recently fetched descriptors and falls back to
// a single-beat Wishbone read on a miss.
module zap_mmu_desc_responder #(
  parameter int unsigned BUF_ENTRIES = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_flush,
  input  logic        i_rd_en,
  input  logic [31:0] i_addr,
  output logic [31:0] o_data,
  output logic        o_dav,
  output logic        o_err,
  output logic        o_busy,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic [31:0] o_wb_adr,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_sel,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_err
);

  localparam int unsigned PTR_W = (BUF_ENTRIES > 1) ? $clog2(BUF_ENTRIES) : 1;
  localparam int unsigned TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TAG_W = 30;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_BUS    = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [TAG_W-1:0]       addr_ff, addr_nxt;
  logic [TAG_W-1:0]       tag_mem  [BUF_ENTRIES];
  logic [31:0]            data_mem [BUF_ENTRIES];
  logic [BUF_ENTRIES-1:0] valid, valid_nxt;
  logic [PTR_W-1:0]       ptr, ptr_nxt;
  logic [TMR_W-1:0]       timer, timer_nxt;

  logic [31:0] data_nxt;
  logic        dav_nxt;
  logic        err_nxt;
  logic        cyc_nxt;
  logic        stb_nxt;
  logic [31:0] adr_nxt;

  logic        hit;
  logic [31:0] hit_data;
  logic        timed_out;
  logic        bus_done;
  logic        bus_fail;
  logic        fill_we;

  // Word offset bits of the request address carry no information.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^i_addr[1:0];

  assign o_wb_we  = 1'b0;
  assign o_wb_sel = 4'hF;
  assign o_busy   = (state != S_IDLE);

  // Associative match; fills only follow misses, so at most one entry hits.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int unsigned i = 0; i < BUF_ENTRIES; i++) begin
      if (valid[PTR_W'(i)] && (tag_mem[PTR_W'(i)] == addr_ff)) begin
        hit      = 1'b1;
        hit_data = hit_data | data_mem[PTR_W'(i)];
      end
    end
    if (i_flush) begin
      hit = 1'b0;
    end
  end

  // Bus completion qualifiers; err wins over ack, ack wins over timeout.
  always_comb begin
    timed_out = (timer == TMR_W'(TIMEOUT));
    bus_done  = i_wb_err || i_wb_ack || timed_out;
    bus_fail  = i_wb_err || (!i_wb_ack && timed_out);
    fill_we   = (state == S_BUS) && i_wb_ack && !i_wb_err;
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (i_rd_en) begin
          state_nxt = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        state_nxt = hit ? S_RESP : S_BUS;
      end
      S_BUS: begin
        if (bus_done) begin
          state_nxt = i_rd_en ? S_RESP : S_IDLE;
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output and datapath next values for the registered outputs and buffer.
  always_comb begin
    data_nxt  = o_data;
    dav_nxt   = 1'b0;
    err_nxt   = 1'b0;
    cyc_nxt   = o_wb_cyc;
    stb_nxt   = o_wb_stb;
    adr_nxt   = o_wb_adr;
    addr_nxt  = addr_ff;
    timer_nxt = timer;
    ptr_nxt   = ptr;
    valid_nxt = valid;

    case (state)
      S_IDLE: begin
        if (i_rd_en) begin
          addr_nxt = i_addr[31:2];
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          data_nxt = hit_data;
          dav_nxt  = 1'b1;
        end else begin
          cyc_nxt   = 1'b1;
          stb_nxt   = 1'b1;
          adr_nxt   = {addr_ff, 2'b00};
          timer_nxt = '0;
        end
      end
      S_BUS: begin
        if (bus_done) begin
          cyc_nxt = 1'b0;
          stb_nxt = 1'b0;
          if (i_rd_en) begin
            dav_nxt = 1'b1;
            if (bus_fail) begin
              data_nxt = '0;
              err_nxt  = 1'b1;
            end else begin
              data_nxt = i_wb_dat;
            end
          end
        end else if (timer != '1) begin
          timer_nxt = timer + TMR_W'(1);
        end
        if (fill_we) begin
          valid_nxt[ptr] = 1'b1;
          ptr_nxt        = (ptr == PTR_W'(BUF_ENTRIES - 1)) ? '0 : ptr + PTR_W'(1);
        end
      end
      S_RESP: begin
        dav_nxt = 1'b0;
      end
      default: begin
        dav_nxt = 1'b0;
      end
    endcase

    // Flush beats a same-cycle fill: the new entry lands invalid.
    if (i_flush) begin
      valid_nxt = '0;
    end
  end

  // Registered outputs and control state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_data   <= '0;
      o_dav    <= 1'b0;
      o_err    <= 1'b0;
      o_wb_cyc <= 1'b0;
      o_wb_stb <= 1'b0;
      o_wb_adr <= '0;
      addr_ff  <= '0;
      timer    <= '0;
      ptr      <= '0;
      valid    <= '0;
    end else begin
      o_data   <= data_nxt;
      o_dav    <= dav_nxt;
      o_err    <= err_nxt;
      o_wb_cyc <= cyc_nxt;
      o_wb_stb <= stb_nxt;
      o_wb_adr <= adr_nxt;
      addr_ff  <= addr_nxt;
      timer    <= timer_nxt;
      ptr      <= ptr_nxt;
      valid    <= valid_nxt;
    end
  end

  // Buffer payload storage; validity is tracked separately.
  always_ff @(posedge i_clk) begin
    if (fill_we) begin
      tag_mem[ptr]  <= addr_ff;
      data_mem[ptr] <= i_wb_dat;
    end
  end

endmodule

// File: tb/tb_zap_mmu_desc_responder.sv
// Self-checking bench for zap_mmu_desc_responder with a behavioural buffer model.
module tb_zap_mmu_desc_responder;

  localparam int NE = 4;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_flush = 1'b0;
  logic        i_rd_en = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] o_data;
  logic        o_dav;
  logic        o_err;
  logic        o_busy;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic [31:0] o_wb_adr;
  logic        o_wb_we;
  logic [3:0]  o_wb_sel;
  logic [31:0] i_wb_dat = '0;
  logic        i_wb_ack = 1'b0;
  logic        i_wb_err = 1'b0;

  int checks = 0;
  int failures = 0;

  zap_mmu_desc_responder #(.BUF_ENTRIES(NE), .TIMEOUT(255)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_rd_en(i_rd_en),
    .i_addr(i_addr), .o_data(o_data), .o_dav(o_dav), .o_err(o_err),
    .o_busy(o_busy), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .o_wb_adr(o_wb_adr), .o_wb_we(o_wb_we), .o_wb_sel(o_wb_sel),
    .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: a list of cached words replaced oldest-first.
  bit          m_valid [NE];
  logic [29:0] m_tag   [NE];
  logic [31:0] m_data  [NE];
  int          m_ptr;

  function automatic int m_lookup(input logic [31:0] a);
    for (int i = 0; i < NE; i++)
      if (m_valid[i] && m_tag[i] == a[31:2]) return i;
    return -1;
  endfunction

  task automatic m_clear(input bit also_ptr);
    for (int i = 0; i < NE; i++) m_valid[i] = 0;
    if (also_ptr) m_ptr = 0;
  endtask

  task automatic m_fill(input logic [31:0] a, input logic [31:0] d, input bit flushed);
    m_tag[m_ptr] = a[31:2];
    m_data[m_ptr] = d;
    m_valid[m_ptr] = 1;
    m_ptr = (m_ptr + 1) % NE;
    if (flushed) m_clear(0);
  endtask

  typedef struct {
    int          lat;
    bit          got_dav;
    logic [31:0] data;
    logic        err;
    int          nbus;
    logic [31:0] adr;
    bit          adr_stable;
    bit          cyc_dropped;
    int          idle_wait;
  } rd_res_t;

  // resp: 0 ack, 1 err, 2 no response, 3 ack+err. abort_at<0 disables abort.
  task automatic do_read(input logic [31:0] addr, input int waits, input int resp,
                         input logic [31:0] wdat, input int abort_at,
                         input bit flush_on_done, output rd_res_t r);
    int cyc;
    bit sent;
    r.idle_wait = 0;
    while (o_busy && r.idle_wait < 10) begin
      @(negedge i_clk);
      r.idle_wait++;
    end
    r.lat = -1; r.got_dav = 0; r.data = '0; r.err = 0; r.nbus = 0;
    r.adr = '0; r.adr_stable = 1; r.cyc_dropped = 0;
    sent = 0;
    i_rd_en = 1'b1;
    i_addr = addr;
    cyc = 0;
    while (cyc < 400) begin
      @(negedge i_clk);
      cyc++;
      i_addr = $urandom;
      i_wb_ack = 1'b0;
      i_wb_err = 1'b0;
      i_flush = 1'b0;
      if (o_dav) begin
        r.got_dav = 1; r.lat = cyc; r.data = o_data; r.err = o_err;
        r.cyc_dropped = !o_wb_cyc && !o_wb_stb;
        break;
      end
      if (sent && !o_busy) break;
      if (o_wb_cyc && o_wb_stb) begin
        if (r.nbus == 0) r.adr = o_wb_adr;
        else if (o_wb_adr !== r.adr) r.adr_stable = 0;
        r.nbus++;
        if (abort_at >= 0 && r.nbus > abort_at) i_rd_en = 1'b0;
        if (r.nbus == waits + 1 && resp != 2) begin
          sent = 1;
          i_wb_dat = wdat;
          i_wb_ack = (resp == 0 || resp == 3);
          i_wb_err = (resp == 1 || resp == 3);
          if (flush_on_done) i_flush = 1'b1;
        end
      end
    end
    i_rd_en = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge i_clk);
    i_reset = 1'b1; i_rd_en = 1'b0; i_flush = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    m_clear(1);
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    i_reset = 1'b1; i_rd_en = 1'b1; i_wb_ack = 1'b1; i_flush = 1'b1; i_addr = 32'h1234;
    @(negedge i_clk);
    @(negedge i_clk);
    checks++; if (o_dav !== 1'b0) begin failures++; $display("FAIL reset_dav got=%0b exp=0", o_dav); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", o_err); end
    checks++; if (o_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%0h exp=0", o_data); end
    checks++; if ({o_wb_cyc, o_wb_stb} !== 2'b00) begin failures++; $display("FAIL reset_cycstb got=%0b exp=00", {o_wb_cyc, o_wb_stb}); end
    checks++; if (o_wb_adr !== 32'h0) begin failures++; $display("FAIL reset_adr got=%0h exp=0", o_wb_adr); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", o_busy); end
    checks++; if ({o_wb_we, o_wb_sel} !== 5'h0F) begin failures++; $display("FAIL reset_we_sel got=%0h exp=0f", {o_wb_we, o_wb_sel}); end
    i_rd_en = 1'b0; i_wb_ack = 1'b0; i_flush = 1'b0;
    i_reset = 1'b0;
    m_clear(1);
  endtask

  task automatic test_miss_hit();
    rd_res_t r;
    do_read(32'h0000_4008, 2, 0, 32'hDEAD_0C12, -1, 0, r);
    m_fill(32'h0000_4008, 32'hDEAD_0C12, 0);
    checks++; if (r.lat !== 5) begin failures++; $display("FAIL miss_lat got=%0d exp=5", r.lat); end
    checks++; if (r.data !== 32'hDEAD_0C12) begin failures++; $display("FAIL miss_data got=%0h exp=dead0c12", r.data); end
    checks++; if (r.err !== 1'b0) begin failures++; $display("FAIL miss_err got=%0b exp=0", r.err); end
    checks++; if (r.adr !== 32'h0000_4008 || !r.adr_stable) begin failures++; $display("FAIL miss_adr got=%0h stable=%0b exp=4008 stable=1", r.adr, r.adr_stable); end
    checks++; if (r.cyc_dropped !== 1'b1) begin failures++; $display("FAIL miss_cyc_drop got=%0b exp=1", r.cyc_dropped); end
    do_read(32'h0000_400B, 0, 0, 32'h0, -1, 0, r);
    checks++; if (r.lat !== 2 || r.nbus !== 0) begin failures++; $display("FAIL hit_lat got=%0d bus=%0d exp=2 bus=0", r.lat, r.nbus); end
    checks++; if (r.data !== 32'hDEAD_0C12) begin failures++; $display("FAIL hit_data got=%0h exp=dead0c12", r.data); end
  endtask

  task automatic test_replacement();
    rd_res_t r;
    logic [31:0] a [5];
    logic [31:0] d [5];
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      a[i] = 32'h0000_1000 + 32'(i) * 32'h40;
      d[i] = $urandom;
      do_read(a[i], i % 2, 0, d[i], -1, 0, r);
      m_fill(a[i], d[i], 0);
      checks++; if (r.lat !== 3 + (i % 2) || r.data !== d[i]) begin failures++; $display("FAIL repl_fill%0d lat=%0d data=%0h exp lat=%0d data=%0h", i, r.lat, r.data, 3 + (i % 2), d[i]); end
    end
    do_read(a[1], 0, 0, 32'h0, -1, 0, r);
    checks++; if (r.nbus !== 0 || r.data !== d[1]) begin failures++; $display("FAIL repl_hit2 bus=%0d data=%0h exp bus=0 data=%0h", r.nbus, r.data, d[1]); end
    do_read(a[0], 0, 0, 32'h5555_0000, -1, 0, r);
    m_fill(a[0], 32'h5555_0000, 0);
    checks++; if (r.nbus !== 1 || r.lat !== 3) begin failures++; $display("FAIL repl_miss1 bus=%0d lat=%0d exp bus=1 lat=3", r.nbus, r.lat); end
  endtask

  task automatic test_error();
    rd_res_t r;
    apply_reset();
    do_read(32'h0000_0500, 0, 0, 32'hCAFE_0001, -1, 0, r);
    m_fill(32'h0000_0500, 32'hCAFE_0001, 0);
    do_read(32'h0000_0100, 1, 1, 32'hFFFF_FFFF, -1, 0, r);
    checks++; if (r.lat !== 4 || r.err !== 1'b1 || r.data !== 32'h0) begin failures++; $display("FAIL err_resp lat=%0d err=%0b data=%0h exp lat=4 err=1 data=0", r.lat, r.err, r.data); end
    do_read(32'h0000_0180, 0, 3, 32'h1111_2222, -1, 0, r);
    checks++; if (r.err !== 1'b1 || r.data !== 32'h0) begin failures++; $display("FAIL ackerr_resp err=%0b data=%0h exp err=1 data=0", r.err, r.data); end
    do_read(32'h0000_0100, 0, 0, 32'h0BAD_F00D, -1, 0, r);
    m_fill(32'h0000_0100, 32'h0BAD_F00D, 0);
    checks++; if (r.nbus !== 1 || r.data !== 32'h0BAD_F00D || r.err !== 1'b0) begin failures++; $display("FAIL err_retry bus=%0d data=%0h err=%0b exp bus=1 data=0badf00d err=0", r.nbus, r.data, r.err); end
    do_read(32'h0000_0180, 0, 0, 32'h3333_4444, -1, 0, r);
    m_fill(32'h0000_0180, 32'h3333_4444, 0);
    checks++; if (r.nbus !== 1) begin failures++; $display("FAIL ackerr_retry bus=%0d exp=1", r.nbus); end
  endtask

  task automatic test_timeout();
    rd_res_t r;
    do_read(32'h0000_0700, 0, 2, 32'h0, -1, 0, r);
    checks++; if (r.nbus !== 256 || r.lat !== 258) begin failures++; $display("FAIL timeout_len bus=%0d lat=%0d exp bus=256 lat=258", r.nbus, r.lat); end
    checks++; if (r.err !== 1'b1 || r.data !== 32'h0 || r.cyc_dropped !== 1'b1) begin failures++; $display("FAIL timeout_resp err=%0b data=%0h drop=%0b exp 1 0 1", r.err, r.data, r.cyc_dropped); end
  endtask

  task automatic test_flush();
    rd_res_t r;
    apply_reset();
    do_read(32'h0000_0200, 0, 0, 32'hAAAA_0200, -1, 0, r);
    m_fill(32'h0000_0200, 32'hAAAA_0200, 0);
    do_read(32'h0000_0300, 1, 0, 32'hBBBB_0300, -1, 1, r);
    m_fill(32'h0000_0300, 32'hBBBB_0300, 1);
    checks++; if (r.data !== 32'hBBBB_0300 || r.err !== 1'b0) begin failures++; $display("FAIL flush_fill data=%0h err=%0b exp bbbb0300 0", r.data, r.err); end
    do_read(32'h0000_0200, 0, 0, 32'hAAAA_0201, -1, 0, r);
    m_fill(32'h0000_0200, 32'hAAAA_0201, 0);
    checks++; if (r.nbus !== 1 || r.data !== 32'hAAAA_0201) begin failures++; $display("FAIL flush_miss_a bus=%0d data=%0h exp bus=1 data=aaaa0201", r.nbus, r.data); end
    do_read(32'h0000_0300, 0, 0, 32'hBBBB_0301, -1, 0, r);
    m_fill(32'h0000_0300, 32'hBBBB_0301, 0);
    checks++; if (r.nbus !== 1 || r.data !== 32'hBBBB_0301) begin failures++; $display("FAIL flush_miss_b bus=%0d data=%0h exp bus=1 data=bbbb0301", r.nbus, r.data); end
  endtask

  task automatic test_abort();
    rd_res_t r;
    logic [31:0] prev;
    apply_reset();
    do_read(32'h0000_0440, 0, 0, 32'h7777_0440, -1, 0, r);
    m_fill(32'h0000_0440, 32'h7777_0440, 0);
    prev = r.data;
    do_read(32'h0000_0900, 2, 0, 32'h9999_0900, 1, 0, r);
    m_fill(32'h0000_0900, 32'h9999_0900, 0);
    checks++; if (r.got_dav !== 1'b0 || o_busy !== 1'b0) begin failures++; $display("FAIL abort_nodav dav=%0b busy=%0b exp 0 0", r.got_dav, o_busy); end
    checks++; if (o_data !== prev) begin failures++; $display("FAIL abort_data_hold got=%0h exp=%0h", o_data, prev); end
    do_read(32'h0000_0900, 0, 0, 32'h0, -1, 0, r);
    checks++; if (r.lat !== 2 || r.nbus !== 0 || r.data !== 32'h9999_0900) begin failures++; $display("FAIL abort_hit lat=%0d bus=%0d data=%0h exp 2 0 99990900", r.lat, r.nbus, r.data); end
  endtask

  task automatic test_reset_mid_bus();
    rd_res_t r;
    int guard;
    @(negedge i_clk);
    i_rd_en = 1'b1; i_addr = 32'h0000_0A00;
    guard = 0;
    while (!o_wb_cyc && guard < 10) begin @(negedge i_clk); guard++; end
    checks++; if (o_wb_cyc !== 1'b1) begin failures++; $display("FAIL rst_bus_start cyc=%0b exp=1", o_wb_cyc); end
    i_reset = 1'b1;
    @(negedge i_clk);
    checks++; if ({o_wb_cyc, o_wb_stb, o_busy, o_dav, o_err} !== 5'b0 || o_data !== 32'h0 || o_wb_adr !== 32'h0) begin failures++; $display("FAIL rst_bus_outs cyc/stb/busy/dav/err=%0b data=%0h adr=%0h exp all 0", {o_wb_cyc, o_wb_stb, o_busy, o_dav, o_err}, o_data, o_wb_adr); end
    i_reset = 1'b0; i_rd_en = 1'b0;
    m_clear(1);
    i_wb_ack = 1'b1; i_wb_dat = 32'hBAD0_0A00;
    @(negedge i_clk);
    i_wb_ack = 1'b0;
    @(negedge i_clk);
    checks++; if ({o_wb_cyc, o_busy, o_dav} !== 3'b0) begin failures++; $display("FAIL rst_stray_ack cyc/busy/dav=%0b exp 000", {o_wb_cyc, o_busy, o_dav}); end
    do_read(32'h0000_0A00, 0, 0, 32'h0A0A_0A0A, -1, 0, r);
    m_fill(32'h0000_0A00, 32'h0A0A_0A0A, 0);
    checks++; if (r.nbus !== 1 || r.data !== 32'h0A0A_0A0A) begin failures++; $display("FAIL rst_no_fill bus=%0d data=%0h exp bus=1 data=0a0a0a0a", r.nbus, r.data); end
  endtask

  task automatic test_back_to_back();
    rd_res_t r;
    do_read(32'h0000_0B00, 0, 0, 32'hB0B0_0001, -1, 0, r);
    m_fill(32'h0000_0B00, 32'hB0B0_0001, 0);
    checks++; if (r.data !== 32'hB0B0_0001) begin failures++; $display("FAIL b2b_first data=%0h exp=b0b00001", r.data); end
    do_read(32'h0000_0B40, 1, 0, 32'hB0B0_0002, -1, 0, r);
    m_fill(32'h0000_0B40, 32'hB0B0_0002, 0);
    checks++; if (r.idle_wait !== 1 || r.lat !== 4 || r.data !== 32'hB0B0_0002) begin failures++; $display("FAIL b2b_second gap=%0d lat=%0d data=%0h exp gap=1 lat=4 data=b0b00002", r.idle_wait, r.lat, r.data); end
  endtask

  task automatic test_random();
    rd_res_t r;
    logic [31:0] a, wd, exp_data;
    int w, resp, idx, exp_lat, exp_nbus;
    logic exp_err;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        m_clear(0);
      end
      a = 32'h0001_0000 + 32'($urandom_range(0, 5)) * 32'h10 + 32'($urandom_range(0, 3));
      w = $urandom_range(0, 3);
      resp = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 0) ? 1 : 3) : 0;
      wd = $urandom;
      idx = m_lookup(a);
      if (idx >= 0) begin
        exp_lat = 2; exp_nbus = 0; exp_data = m_data[idx]; exp_err = 0;
      end else begin
        exp_lat = 3 + w; exp_nbus = w + 1;
        exp_err = (resp != 0);
        exp_data = exp_err ? 32'h0 : wd;
      end
      do_read(a, w, resp, wd, -1, 0, r);
      if (idx < 0 && resp == 0) m_fill(a, wd, 0);
      checks++;
      if (r.lat !== exp_lat || r.nbus !== exp_nbus || r.data !== exp_data || r.err !== exp_err) begin
        failures++;
        $display("FAIL rand%0d addr=%0h lat=%0d bus=%0d data=%0h err=%0b exp lat=%0d bus=%0d data=%0h err=%0b",
                 n, a, r.lat, r.nbus, r.data, r.err, exp_lat, exp_nbus, exp_data, exp_err);
      end
    end
  endtask

  initial begin
    m_clear(1);
    test_reset();
    test_miss_hit();
    test_replacement();
    test_error();
    test_timeout();
    test_flush();
    test_abort();
    test_reset_mid_bus();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
